// File: rtl/tt_sweep_checker.sv
// Sweeps {a,b,c,d} through all 16 minterms, samples f_in after a settle window and
// checks each sample against EXPECT_MASK, reporting error count, fail map and first failure.
module tt_sweep_checker #(
    parameter logic [15:0] EXPECT_MASK   = 16'hB0BB,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] fail_map,
    output logic [3:0]  first_fail,
    output logic        first_fail_valid
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    logic [1:0] state;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic [3:0] stim;
    logic       mismatch;
    logic [4:0] err_next;

    assign {a, b, c, d} = stim;

    // err_next folds in the current sample so the final vector's result reaches pass.
    always_comb begin
        mismatch = (f_in != EXPECT_MASK[idx]);
        err_next = err_count + 5'(mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= '0;
            cnt              <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            fail_map         <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state            <= RUN;
                        idx              <= '0;
                        cnt              <= '0;
                        stim             <= '0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        fail_map         <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt < SETTLE) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        if (mismatch) begin
                            err_count     <= err_next;
                            fail_map[idx] <= 1'b1;
                            if (!first_fail_valid) begin
                                first_fail       <= idx;
                                first_fail_valid <= 1'b1;
                            end
                        end
                        if (idx != 4'hF) begin
                            idx  <= idx + 4'd1;
                            stim <= idx + 4'd1;
                            cnt  <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 5'd0);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: table of f_in fault models plus hand-written
// sequences for reset abort, start-while-busy and a zero-settle instance.
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        f_in;
    logic        a, b, c, d, busy, done, pass, ffv;
    logic [4:0]  err_count;
    logic [15:0] fail_map;
    logic [3:0]  first_fail;

    logic        start0 = 1'b0;
    logic        f0;
    logic        a0, b0, c0, d0, busy0, done0, pass0, ffv0;
    logic [4:0]  err0;
    logic [15:0] map0;
    logic [3:0]  ff0;

    int          checks = 0;
    int          errors = 0;
    int          mode = 0;
    logic [15:0] gold = 16'hB0BB;
    logic [3:0]  stim, stim0;

    always #5 clk = ~clk;

    tt_sweep_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_map(fail_map), .first_fail(first_fail),
        .first_fail_valid(ffv)
    );

    tt_sweep_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .f_in(f0),
        .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_map(map0), .first_fail(ff0),
        .first_fail_valid(ffv0)
    );

    assign stim  = {a, b, c, d};
    assign stim0 = {a0, b0, c0, d0};
    assign f0    = gold[stim0];

    // f_in models: 0 correct, 1 stuck-at-0, 2 inverted, 3 wrong at m6
    always_comb begin
        case (mode)
            1:       f_in = 1'b0;
            2:       f_in = ~gold[stim];
            3:       f_in = (stim == 4'd6) ? 1'b1 : gold[stim];
            default: f_in = gold[stim];
        endcase
    end

    typedef struct {
        int          mode;
        logic [4:0]  err;
        logic [15:0] map;
        logic [3:0]  ff;
        logic        ffv;
        logic        pass;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulses start, checks accept-time clearing and stimulus stepping, returns latency.
    task automatic run_sweep(output int lat);
        bit stim_ok;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_clear", {pass, err_count, fail_map, ffv}, 0);
        stim_ok = (stim == 4'd0);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (stim != 4'(k / 3)) stim_ok = 1'b0;
        end
        check("stim_steps", stim_ok, 1);
        check("busy_at_done", busy, 0);
    endtask

    initial begin
        int lat;
        int ndone;

        vecs[0] = '{0, 5'd0,  16'h0000, 4'd0, 1'b0, 1'b1};
        vecs[1] = '{1, 5'd9,  16'hB0BB, 4'd0, 1'b1, 1'b0};
        vecs[2] = '{2, 5'd16, 16'hFFFF, 4'd0, 1'b1, 1'b0};
        vecs[3] = '{3, 5'd1,  16'h0040, 4'd6, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {stim, busy, done, pass, err_count, fail_map, first_fail, ffv}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            run_sweep(lat);
            check("latency", lat, 48);
            check("err_count", err_count, vecs[i].err);
            check("fail_map", fail_map, vecs[i].map);
            check("first_fail_valid", ffv, vecs[i].ffv);
            if (vecs[i].ffv) check("first_fail", first_fail, vecs[i].ff);
            check("pass", pass, vecs[i].pass);
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
            check("results_hold", {pass, err_count, fail_map}, {vecs[i].pass, vecs[i].err, vecs[i].map});
            @(posedge clk); #1;
        end

        // Reset mid-sweep at idx 5
        mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && stim != 4'd5; k++) @(posedge clk);
        #1;
        check("reached_idx5", stim, 5);
        rst_n = 1'b0;
        #1;
        check("async_reset_clear",
              {stim, busy, done, pass, err_count, fail_map, first_fail, ffv}, 0);
        ndone = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("no_done_after_abort", ndone, 0);
        run_sweep(lat);
        check("post_reset_latency", lat, 48);
        check("post_reset_pass", pass, 1);
        @(posedge clk); #1;

        // Start pulses during RUN are ignored
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 70; k++) begin
            start = (k == 10 || k == 20 || k == 40 || k == 47);
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                check("busy_start_latency", k, 48);
            end
        end
        check("single_done", ndone, 1);
        check("idle_after_done", busy, 0);
        mode = 0;
        run_sweep(lat);
        check("second_latency", lat, 48);
        check("second_pass", {pass, err_count}, {1'b1, 5'd0});
        @(posedge clk); #1;

        // Zero-settle instance
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done0) begin
                lat = k;
                break;
            end
            if (stim0 != 4'(k)) check("settle0_stim", stim0, 4'(k));
        end
        check("settle0_latency", lat, 16);
        check("settle0_pass", {pass0, err0, map0, ffv0}, {1'b1, 5'd0, 16'h0000, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Self-checking stimulus/response engine for 4-input combinational lab functions. It drives all 16 input combinations {a,b,c,d} in ascending order into a DUT such as the lab's 4-input f-function and samples the DUT output f after a settle window. Each sample is compared against a parameterised 16-entry truth table, and the block accumulates an error count, a per-minterm fail map and the first failing index. It sits on the driver/checker side of the 4-in/1-out interface and replaces open-loop display-based checking with synthesizable pass/fail hardware.

Parameters:
EXPECT_MASK, 16'hB0BB, expected f per minterm; bit i = f for {a,b,c,d}=i, with a as MSB. The default has zeros at m2, m6, m8-m11 and m14.
SETTLE_CYCLES, 2, extra cycles each vector is held before f_in is sampled; legal range 0..15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a sweep; honoured only in IDLE
f_in  input  1  DUT output under test
a  output  1  stimulus MSB, registered
b  output  1  stimulus, registered
c  output  1  stimulus, registered
d  output  1  stimulus LSB, registered
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse at the end of a sweep
pass  output  1  1 when the last completed sweep had zero errors
err_count  output  5  number of mismatches in the last sweep (0..16)
fail_map  output  16  bit i set if minterm i mismatched
first_fail  output  4  lowest mismatching minterm index
first_fail_valid  output  1  first_fail holds a valid index

Behaviour:
- Reset (asynchronous, active-low): the FSM goes to IDLE and every output returns to 0, including a..d, busy, done, pass, err_count, fail_map, first_fail and first_fail_valid. Internal idx and settle counter are cleared. Reset mid-sweep aborts the sweep; no done pulse is produced.
- FSM states are IDLE, RUN and DONE.
- IDLE: on a rising edge with start=1:
  - go to RUN with idx=0 and cnt=0;
  - clear err_count, fail_map, pass, first_fail and first_fail_valid;
  - set busy=1 and drive {a,b,c,d}=0.
- RUN: {a,b,c,d}=idx is held for SETTLE_CYCLES+1 cycles. On each edge:
  - If cnt<SETTLE_CYCLES, increment cnt.
  - If cnt==SETTLE_CYCLES, sample f_in and compare it with EXPECT_MASK[idx].
  - On mismatch: err_count += 1 and fail_map[idx] <= 1. If first_fail_valid=0, load first_fail=idx and set first_fail_valid=1.
  - If idx!=15, then idx += 1 and cnt = 0.
  - If idx==15, go to DONE; busy drops at this edge.
- DONE: done=1 for exactly one cycle, with pass=(err_count==0) becoming valid in the same cycle. Next edge returns to IDLE.
- Result outputs hold until the next accepted start or reset.
- Sweep latency, measured from the start-accept edge to done high: 16*(SETTLE_CYCLES+1) cycles. With the default that is 48 cycles.
- start asserted in RUN or DONE is ignored and not queued. Holding start high continuously re-triggers a new sweep in the first IDLE cycle after done.
- The idx counter never wraps during a sweep; exactly 16 comparisons are made per sweep.
- err_count is 5 bits so the all-fail value 16 is representable; no saturation is needed.
- f_in is sampled with the same clk as the stimulus register. The DUT is combinational, so the settle window covers its delay; with SETTLE_CYCLES=0 each vector is driven and sampled in one cycle.
- If the comparison on the final vector (idx 15) mismatches, it is counted before DONE; the final err_count, fail_map and pass include it.

Test Plan:
1. Correct behavioural model of the default function on f_in, pulse start -> done at cycle 48 after accept; pass=1, err_count=0, fail_map=16'h0000, first_fail_valid=0. Stimulus a..d steps 0..15, each value held 3 cycles.
2. f_in tied to 0 -> err_count=9, fail_map=16'hB0BB, first_fail=0, first_fail_valid=1, pass=0.
3. f_in = inverted correct model -> err_count=16, fail_map=16'hFFFF, first_fail=0, pass=0.
4. Correct model with a single fault at m6 (f=1 at 0110) -> err_count=1, fail_map=16'h0040, first_fail=6, pass=0.
5. Start a sweep; at idx=5 assert rst_n=0 for 2 cycles -> all outputs 0 immediately and no done pulse. A fresh start then completes normally with pass=1.
6. Start pulses during RUN -> ignored, exactly one done. A second start after done with a correct model -> previous fail results cleared at accept; pass=1 at the new done. Repeat the sweep with SETTLE_CYCLES=0 -> done 16 cycles after accept.
